// File: rtl/muldiv_pkg.sv
// Shared types for the iterative RV-M multiply/divide unit: funct3 op codes,
// FSM states and the M-extension funct7 value.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREP,
    ST_ITER,
    ST_DONE
  } state_e;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate, used for operand magnitudes and
// for the final result sign fixup.
module muldiv_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV-M multiply/divide: one multiplier bit or one quotient bit per
// cycle, sharing a 2*XLEN accumulator between shift-add and restoring divide.
//
//   state   | meaning
//   IDLE    | waiting for a request, in_ready high
//   PREP    | take magnitudes, record result sign, catch div-by-zero/overflow
//   ITER    | XLEN shift-add or restoring-divide steps
//   DONE    | register fixed-up result, hold it until out_ready
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int CNT_W = $clog2(XLEN);

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [XLEN-1:0]     a_q, a_d, b_q, b_d;
  logic [TAG_W-1:0]    tag_q, tag_d, out_tag_q, out_tag_d;
  logic                neg_q, neg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN:0]       rem_q, rem_d;
  logic                out_valid_q, out_valid_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic [2:0]          op_bits;
  logic                is_div, signed_a, signed_b, sign_a, sign_b, div0, ovf, q_bit;
  logic [XLEN-1:0]     abs_a, abs_b;
  logic [XLEN:0]       mul_sum, shifted;
  logic [XLEN+1:0]     diff;
  logic [2*XLEN-1:0]   raw, fixed;

  assign op_bits  = op_q;
  assign is_div   = op_bits[2];
  assign signed_a = (op_q == OP_MULH) || (op_q == OP_MULHSU) || (op_q == OP_DIV) || (op_q == OP_REM);
  assign signed_b = (op_q == OP_MULH) || (op_q == OP_DIV) || (op_q == OP_REM);
  assign sign_a   = signed_a & a_q[XLEN-1];
  assign sign_b   = signed_b & b_q[XLEN-1];
  assign div0     = is_div && (b_q == '0);
  assign ovf      = is_div && signed_b && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == {XLEN{1'b1}});

  muldiv_signfix #(.W(XLEN)) u_abs_a (.val(a_q), .neg(sign_a), .res(abs_a));
  muldiv_signfix #(.W(XLEN)) u_abs_b (.val(b_q), .neg(sign_b), .res(abs_b));

  // Multiply: low half of acc holds the remaining multiplier bits.
  assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);

  // Divide: low half of acc shifts the dividend out and the quotient in.
  assign shifted = {rem_q[XLEN-1:0], acc_q[XLEN-1]};
  assign diff    = {1'b0, shifted} - {2'b00, b_q};
  assign q_bit   = ~diff[XLEN+1];

  assign raw = !is_div    ? acc_q :
               op_bits[1] ? {{(XLEN-1){1'b0}}, rem_q} :
                            {{XLEN{1'b0}}, acc_q[XLEN-1:0]};

  muldiv_signfix #(.W(2*XLEN)) u_fix (.val(raw), .neg(neg_q), .res(fixed));

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    tag_d       = tag_q;
    neg_d       = neg_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    rem_d       = rem_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    out_tag_d   = out_tag_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_PREP;
          op_d    = op_e'(op);
          a_d     = a;
          b_d     = b;
          tag_d   = in_tag;
        end
      end
      ST_PREP: begin
        neg_d = (is_div && op_bits[1]) ? sign_a : (sign_a ^ sign_b);
        if (div0 || ovf) begin
          state_d = ST_DONE;
          neg_d   = 1'b0;
          acc_d   = {{XLEN{1'b0}}, (div0 ? {XLEN{1'b1}} : a_q)};
          rem_d   = div0 ? {1'b0, a_q} : '0;
        end else begin
          state_d = ST_ITER;
          cnt_d   = CNT_W'(XLEN - 1);
          acc_d   = {{XLEN{1'b0}}, abs_a};
          b_d     = abs_b;
          rem_d   = '0;
        end
      end
      ST_ITER: begin
        if (is_div) begin
          acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], q_bit};
          rem_d = q_bit ? diff[XLEN:0] : shifted;
        end else begin
          acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          result_d    = (is_div || (op_q == OP_MUL)) ? fixed[XLEN-1:0] : fixed[2*XLEN-1:XLEN];
          out_tag_d   = tag_q;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (kill) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_MUL;
      a_q         <= '0;
      b_q         <= '0;
      tag_q       <= '0;
      neg_q       <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      out_tag_q   <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      tag_q       <= tag_d;
      neg_q       <= neg_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at XLEN=32, 8 and 64 with hand-computed results,
// latencies, backpressure, kill and mid-operation reset.
module tb_muldiv_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, kill, out_ready;
  logic [2:0]  op;
  logic [4:0]  in_tag;

  logic        iv32, ir32, ov32, busy32;
  logic [31:0] a32, b32, res32;
  logic [4:0]  tag32;

  logic        iv8, ir8, ov8, busy8;
  logic [7:0]  a8, b8, res8;
  logic [4:0]  tag8;

  logic        iv64, ir64, ov64, busy64;
  logic [63:0] a64, b64, res64;
  logic [4:0]  tag64;

  int checks = 0;
  int errors = 0;
  int tag_ctr = 1;

  muldiv_unit #(.XLEN(32), .TAG_W(5)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .op(op), .a(a32), .b(b32),
    .in_tag(in_tag), .kill(kill), .out_valid(ov32), .out_ready(out_ready),
    .result(res32), .out_tag(tag32), .busy(busy32));

  muldiv_unit #(.XLEN(8), .TAG_W(5)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .op(op), .a(a8), .b(b8),
    .in_tag(in_tag), .kill(kill), .out_valid(ov8), .out_ready(out_ready),
    .result(res8), .out_tag(tag8), .busy(busy8));

  muldiv_unit #(.XLEN(64), .TAG_W(5)) dut64 (
    .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .op(op), .a(a64), .b(b64),
    .in_tag(in_tag), .kill(kill), .out_valid(ov64), .out_ready(out_ready),
    .result(res64), .out_tag(tag64), .busy(busy64));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic get_ov(input int w);
    case (w)
      8:       return ov8;
      64:      return ov64;
      default: return ov32;
    endcase
  endfunction

  function automatic logic [63:0] get_res(input int w);
    case (w)
      8:       return {56'd0, res8};
      64:      return res64;
      default: return {32'd0, res32};
    endcase
  endfunction

  function automatic logic [4:0] get_tag(input int w);
    case (w)
      8:       return tag8;
      64:      return tag64;
      default: return tag32;
    endcase
  endfunction

  function automatic logic get_ir(input int w);
    case (w)
      8:       return ir8 & ~busy8;
      64:      return ir64 & ~busy64;
      default: return ir32 & ~busy32;
    endcase
  endfunction

  // Present a request for one edge, then scramble the inputs.
  task automatic issue(input int w, input logic [2:0] o, input logic [63:0] av,
                       input logic [63:0] bv, input logic [4:0] t);
    @(negedge clk);
    op = o;
    in_tag = t;
    case (w)
      8:       begin iv8 = 1'b1;  a8 = av[7:0];   b8 = bv[7:0];   end
      64:      begin iv64 = 1'b1; a64 = av;       b64 = bv;       end
      default: begin iv32 = 1'b1; a32 = av[31:0]; b32 = bv[31:0]; end
    endcase
    @(posedge clk);
    #1;
    iv8 = 1'b0; iv32 = 1'b0; iv64 = 1'b0;
    a8 = ~a8; b8 = ~b8; a32 = ~a32; b32 = ~b32; a64 = ~a64; b64 = ~b64;
    op = ~o;
    in_tag = ~t;
  endtask

  task automatic wait_out(input int w, output int n);
    n = 0;
    while (!get_ov(w) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic run(input string nm, input int w, input logic [2:0] o,
                     input logic [63:0] av, input logic [63:0] bv,
                     input logic [63:0] exp, input int lat);
    int n;
    logic [4:0] t;
    t = 5'(tag_ctr);
    tag_ctr++;
    chk({nm, " ready"}, 64'(get_ir(w)), 64'd1);
    issue(w, o, av, bv, t);
    wait_out(w, n);
    chk({nm, " lat"}, 64'(n), 64'(lat));
    chk({nm, " res"}, get_res(w), exp);
    chk({nm, " tag"}, 64'(get_tag(w)), 64'(t));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({nm, " drain"}, 64'(get_ov(w)), 64'd0);
  endtask

  initial begin
    int n;
    int seen;
    rst = 1'b1; kill = 1'b0; out_ready = 1'b0; op = 3'd0; in_tag = 5'd0;
    iv32 = 1'b0; a32 = '0; b32 = '0;
    iv8  = 1'b0; a8  = '0; b8  = '0;
    iv64 = 1'b0; a64 = '0; b64 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst in_ready", 64'(ir32), 64'd1);
    chk("rst out_valid", 64'(ov32), 64'd0);
    chk("rst result", 64'(res32), 64'd0);
    chk("rst out_tag", 64'(tag32), 64'd0);
    chk("rst busy", 64'(busy32), 64'd0);

    run("mul",    32, 3'b000, 64'd7,          64'hFFFFFFFD, 64'hFFFFFFEB, 34);
    run("mulh",   32, 3'b001, 64'h80000000,   64'h80000000, 64'h40000000, 34);
    run("mulhu",  32, 3'b011, 64'hFFFFFFFF,   64'hFFFFFFFF, 64'hFFFFFFFE, 34);
    run("mulhsu", 32, 3'b010, 64'hFFFFFFFF,   64'hFFFFFFFF, 64'hFFFFFFFF, 34);
    run("div",    32, 3'b100, 64'hFFFFFFF9,   64'd2,        64'hFFFFFFFD, 34);
    run("rem",    32, 3'b110, 64'hFFFFFFF9,   64'd2,        64'hFFFFFFFF, 34);
    run("divu",   32, 3'b101, 64'd100,        64'd7,        64'd14,       34);
    run("remu",   32, 3'b111, 64'd100,        64'd7,        64'd2,        34);
    run("divu0",  32, 3'b101, 64'd5,          64'd0,        64'hFFFFFFFF, 2);
    run("remu0",  32, 3'b111, 64'd5,          64'd0,        64'd5,        2);
    run("divovf", 32, 3'b100, 64'h80000000,   64'hFFFFFFFF, 64'h80000000, 2);
    run("removf", 32, 3'b110, 64'h80000000,   64'hFFFFFFFF, 64'd0,        2);

    // Backpressure: DONE held for 10 cycles, then release with a request waiting.
    issue(32, 3'b011, 64'hFFFFFFFF, 64'hFFFFFFFF, 5'd17);
    wait_out(32, n);
    chk("bp lat", 64'(n), 64'd34);
    repeat (10) begin
      @(posedge clk);
      #1;
      chk("bp res", 64'(res32), 64'hFFFFFFFE);
      chk("bp tag", 64'(tag32), 64'd17);
      chk("bp in_ready", 64'(ir32), 64'd0);
      chk("bp valid", 64'(ov32), 64'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    iv32 = 1'b1; op = 3'b101; a32 = 32'd100; b32 = 32'd7; in_tag = 5'd3;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp release valid", 64'(ov32), 64'd0);
    chk("bp release in_ready", 64'(ir32), 64'd1);
    chk("bp no accept on handshake", 64'(busy32), 64'd0);
    @(posedge clk);
    #1;
    iv32 = 1'b0; a32 = 32'd1; b32 = 32'd1;
    chk("bp accept next cycle", 64'(busy32), 64'd1);
    wait_out(32, n);
    chk("bp next lat", 64'(n), 64'd34);
    chk("bp next res", 64'(res32), 64'd14);
    chk("bp next tag", 64'(tag32), 64'd3);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Kill mid-ITER.
    issue(32, 3'b000, 64'd3, 64'd5, 5'd9);
    repeat (10) @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    chk("kill busy", 64'(busy32), 64'd0);
    chk("kill valid", 64'(ov32), 64'd0);
    chk("kill in_ready", 64'(ir32), 64'd1);
    seen = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (ov32) seen++;
    end
    chk("kill stale", 64'(seen), 64'd0);

    // Kill together with in_valid in IDLE: request is dropped.
    @(negedge clk);
    kill = 1'b1; iv32 = 1'b1; op = 3'b000; a32 = 32'd2; b32 = 32'd2;
    @(posedge clk);
    #1;
    kill = 1'b0; iv32 = 1'b0;
    chk("kill blocks accept", 64'(busy32), 64'd0);

    // Reset mid-ITER; result was 14 beforehand.
    issue(32, 3'b000, 64'd3, 64'd5, 5'd11);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid rst valid", 64'(ov32), 64'd0);
    chk("mid rst result", 64'(res32), 64'd0);
    chk("mid rst tag", 64'(tag32), 64'd0);
    chk("mid rst busy", 64'(busy32), 64'd0);
    chk("mid rst in_ready", 64'(ir32), 64'd1);
    seen = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (ov32) seen++;
    end
    chk("mid rst stale", 64'(seen), 64'd0);

    run("mul8",  8,  3'b000, 64'h80, 64'h80, 64'h00, 10);
    run("mulh8", 8,  3'b001, 64'h80, 64'h80, 64'h40, 10);
    run("div64", 64, 3'b100, 64'hFFFFFFFFFFFFFFFF, 64'd1, 64'hFFFFFFFFFFFFFFFF, 66);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
